// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI read-channel types and width constants
package axi_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_DATA_BITS = 32;

  typedef enum logic {IDLE, LOCKED} r_arb_state_e;
  typedef enum logic {SEL_S0, SEL_S1} slave_sel_e;

  function automatic slave_sel_e other_sel(input slave_sel_e s);
    return (s == SEL_S0) ? SEL_S1 : SEL_S0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin picker, one-hot grant
module rr_arb2
  import axi_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  // i_ptr breaks ties only; a lone requester always wins
  assign o_grant[0] = i_req[0] & (~i_req[1] | ~i_ptr);
  assign o_grant[1] = i_req[1] & (~i_req[0] |  i_ptr);

endmodule

// File: rtl/r_channel_arbiter.sv
// rtl/r_channel_arbiter.sv - round-robin R-channel arbiter, burst-locked, two slaves
module r_channel_arbiter
  import axi_pkg::*;
#(
  parameter int IDS_BITS  = AXI_IDS_BITS,
  parameter int ID_BITS   = AXI_ID_BITS,
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int MAX_BEATS = 16,
  localparam int CNT_BITS = $clog2(MAX_BEATS) + 1
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [IDS_BITS-1:0]  RID_S0,
  input  logic [DATA_BITS-1:0] RDATA_S0,
  input  logic [1:0]           RRESP_S0,
  input  logic                 RLAST_S0,
  input  logic                 RVALID_S0,
  output logic                 RREADY_S0,
  input  logic [IDS_BITS-1:0]  RID_S1,
  input  logic [DATA_BITS-1:0] RDATA_S1,
  input  logic [1:0]           RRESP_S1,
  input  logic                 RLAST_S1,
  input  logic                 RVALID_S1,
  output logic                 RREADY_S1,
  output logic [ID_BITS-1:0]   RID,
  output logic [DATA_BITS-1:0] RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic [CNT_BITS-1:0]  beat_cnt,
  output logic                 proto_err
);

  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(MAX_BEATS);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(MAX_BEATS - 1);

  r_arb_state_e        r_state;
  slave_sel_e          r_owner;
  slave_sel_e          r_rr_ptr;
  logic [CNT_BITS-1:0] r_beat_cnt;
  logic                r_proto_err;
  logic                r_pending;

  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  slave_sel_e          w_sel;
  logic                w_sel_any;
  logic                w_en_s0;
  logic                w_en_s1;
  logic                w_hs;
  logic                w_hs_last;
  logic                w_unused_id;

  assign w_req       = {RVALID_S1, RVALID_S0};
  assign w_unused_id = ^{RID_S0[IDS_BITS-1:ID_BITS], RID_S1[IDS_BITS-1:ID_BITS]};

  rr_arb2 u_rr_arb2 (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr == SEL_S1),
    .o_grant (w_grant)
  );

  // While locked the owner stays selected even with its RVALID low
  always_comb begin
    w_sel_any = 1'b0;
    w_sel     = SEL_S0;
    if (r_state == LOCKED) begin
      w_sel_any = 1'b1;
      w_sel     = r_owner;
    end else if (w_grant[1]) begin
      w_sel_any = 1'b1;
      w_sel     = SEL_S1;
    end else if (w_grant[0]) begin
      w_sel_any = 1'b1;
    end
  end

  assign w_en_s0 = ARESETn & w_sel_any & (w_sel == SEL_S0);
  assign w_en_s1 = ARESETn & w_sel_any & (w_sel == SEL_S1);

  assign RVALID    = (w_en_s0 & RVALID_S0) | (w_en_s1 & RVALID_S1);
  assign RLAST     = (w_en_s0 & RLAST_S0)  | (w_en_s1 & RLAST_S1);
  assign RRESP     = ({2{w_en_s0}} & RRESP_S0) | ({2{w_en_s1}} & RRESP_S1);
  assign RID       = ({ID_BITS{w_en_s0}} & RID_S0[ID_BITS-1:0])
                   | ({ID_BITS{w_en_s1}} & RID_S1[ID_BITS-1:0]);
  assign RDATA     = ({DATA_BITS{w_en_s0}} & RDATA_S0) | ({DATA_BITS{w_en_s1}} & RDATA_S1);
  assign RREADY_S0 = w_en_s0 & RREADY;
  assign RREADY_S1 = w_en_s1 & RREADY;

  assign w_hs      = RVALID & RREADY;
  assign w_hs_last = w_hs & RLAST;

  assign beat_cnt  = r_beat_cnt;
  assign proto_err = r_proto_err;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state     <= IDLE;
      r_owner     <= SEL_S0;
      r_rr_ptr    <= SEL_S0;
      r_beat_cnt  <= '0;
      r_proto_err <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      // A presented beat that has not been accepted must stay valid
      r_pending <= RVALID & ~RREADY;

      if (w_hs_last) begin
        r_beat_cnt <= '0;
      end else if (w_hs && (r_beat_cnt != CNT_MAX)) begin
        r_beat_cnt <= r_beat_cnt + CNT_BITS'(1);
      end

      if ((w_hs && !RLAST && (r_beat_cnt == CNT_LAST)) ||
          ((r_state == LOCKED) && r_pending && !RVALID)) begin
        r_proto_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (RVALID) begin
            if (w_hs_last) begin
              r_rr_ptr <= other_sel(w_sel);
            end else begin
              r_state <= LOCKED;
              r_owner <= w_sel;
            end
          end
        end
        LOCKED: begin
          if (w_hs_last) begin
            r_state  <= IDLE;
            r_rr_ptr <= other_sel(r_owner);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/r_channel_arbiter.md
# r_channel_arbiter

AXI read-data (R) channel arbiter sharing one master-side R port between two slaves (S0, S1). It replaces fixed-priority muxing with round-robin selection and holds the grant for a full burst, from the first beat through the RLAST handshake. It routes RREADY back to the granted slave only and flags R-channel protocol violations. It sits in the interconnect between the slave R outputs and the master R input.

## Interface
Parameters:
- IDS_BITS, 8, slave-side ID width ({master idx, ID}).
- ID_BITS, 4, master-side ID width; RID = RID_Sx[ID_BITS-1:0].
- DATA_BITS, 32, data width.
- MAX_BEATS, 16, legal beats per burst (AXI4 LEN ≤ 15).

Ports:
- ACLK  in  1  clock; all state updates on rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- RID_S0/RID_S1  in  IDS_BITS  slave read ID.
- RDATA_S0/RDATA_S1  in  DATA_BITS  slave read data.
- RRESP_S0/RRESP_S1  in  2  slave response.
- RLAST_S0/RLAST_S1  in  1  slave last beat.
- RVALID_S0/RVALID_S1  in  1  slave valid.
- RREADY_S0/RREADY_S1  out  1  ready routed to the granted slave only.
- RID  out  ID_BITS  master read ID.
- RDATA  out  DATA_BITS  master data.
- RRESP  out  2  master response.
- RLAST  out  1  master last.
- RVALID  out  1  master valid.
- RREADY  in  1  master ready.
- beat_cnt  out  clog2(MAX_BEATS)+1  beats accepted in the current burst.
- proto_err  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, LOCKED(owner ∈ {S0,S1}). Register rr_ptr holds the preferred slave; reset value selects S0.
- IDLE selection:
  - Only one RVALID_Sx high: that slave wins.
  - Both high: rr_ptr wins.
  - Neither high: no winner.
- IDLE forwarding: the winner is forwarded combinationally in the same cycle, giving zero-latency first beat.
- LOCKED forwarding: only the owner is forwarded. The other slave sees RREADY_Sx=0 regardless of its RVALID.
- Forwarding: RID/RDATA/RRESP/RLAST/RVALID come from the selected slave. RREADY_Sx = RREADY for the selected slave and 0 for the other. With no selection, all master outputs are 0.
- Handshake definition: RVALID && RREADY.
- Transitions:
  - IDLE → LOCKED(winner): RVALID=1 and not (handshake && RLAST). This covers both a stalled beat and a non-last beat, and keeps RVALID/payload stable per AXI.
  - IDLE, handshake && RLAST: single-beat burst. Stay IDLE and set rr_ptr to the non-winner.
  - LOCKED, handshake && RLAST → IDLE. Set rr_ptr to the non-owner.
  - LOCKED otherwise: stay.
- beat_cnt:
  - Increments on each handshake.
  - Clears to 0 on the cycle after the RLAST handshake.
  - Saturates at MAX_BEATS.
- proto_err set (sticky, cleared only by reset) when either:
  - a non-last handshake occurs while beat_cnt == MAX_BEATS-1;
  - in LOCKED, the owner deasserts RVALID before a handshake completes.
- On proto_err the arbiter keeps operating and does not force release.

## Timing
- Data path is combinational, with zero cycles slave→master latency. State, rr_ptr, beat_cnt and proto_err are registered.
- Reset:
  - While ARESETn=0 at a rising edge, the next state is IDLE, rr_ptr=S0, beat_cnt=0, proto_err=0.
  - While ARESETn is low, all outputs (RID, RDATA, RRESP, RLAST, RVALID, RREADY_S0/S1) are forced to 0 combinationally.
- Reset mid-burst: the lock is dropped. After release, selection restarts from IDLE with S0 preferred.
- Simultaneous events:
  - RLAST handshake on S0 while S1 is valid: S1 is forwarded on the next cycle, with no idle bubble required.
  - Both slaves raise RVALID in the same cycle: rr_ptr decides.
- Back-to-back single-beat bursts from both slaves alternate every cycle.

## Structure
- Shared package axi_pkg:
  - r_arb_state_e enum {IDLE, LOCKED}.
  - slave_sel_e enum {SEL_S0, SEL_S1}.
  - Width constants aligned with `AXI_IDS_BITS, `AXI_ID_BITS, `AXI_DATA_BITS.
- One sub-module: rr_arb2, a 2-requester round-robin picker (req[1:0], ptr → grant one-hot, combinational). The top level holds the FSM, lock, counters and the forwarding mux.

## Test plan
- Reset: ARESETn=0 for 2 cycles with RVALID_S1=1 → all outputs 0. On release, S1 is forwarded with RREADY_S1=RREADY.
- Contention: both slaves assert RVALID with 4-beat bursts, RREADY=1 → S0 beats 0-3 (RID=RID_S0[3:0]), then S1 beats 0-3. Grant does not switch mid-burst, and RREADY_S1=0 during the S0 burst.
- Backpressure: S0 single beat, RREADY=0 for 3 cycles while S1 is valid → RVALID/RDATA stay stable from S0. After the handshake, S1 is forwarded the next cycle.
- Round-robin: both slaves issue continuous single-beat bursts → grants alternate S0, S1, S0, S1; beat_cnt returns to 0 after each.
- Protocol error: S0 sends 17 beats with RLAST low → proto_err=1 at the 16th handshake and stays set until reset.
- Valid drop: S0 asserts RVALID, RREADY=0, then S0 deasserts RVALID → proto_err=1 and the state remains LOCKED(S0).
